// File: rtl/fp32_norm3_pkg.sv
// Shared types and constants for the fp32_norm3 scheduler slice.
package fp32_norm3_pkg;

    localparam int LAT_DEFAULT = 7;
    localparam int ID_MAX_W    = 3;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp32_norm3_fifo.sv
// First-word-fall-through result FIFO; head data reads as zero while empty.
module fp32_norm3_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 98,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rd_fire, wr_fire;

    // A write at full is legal only when the head leaves in the same cycle.
    assign rd_fire  = rd_en && (count != '0);
    assign wr_fire  = wr_en && ((count != CW'(DEPTH)) || rd_fire);
    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(wr_fire) - CW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fp32_normalize3.sv
// FP32 3-vector normalize core: combinational fixed-point datapath followed by a
// LAT-deep result pipeline. Denormal inputs are treated as zero; zero vector gives zero.
module fp32_normalize3 #(
    parameter int LAT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [31:0] in_z,
    output logic        out_valid,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_z
);

    // Mantissa aligned to the largest exponent of the three components.
    function automatic logic [23:0] aligned(input logic [30:0] f, input logic [7:0] emax);
        logic [7:0] sh;
        sh = emax - f[30:23];
        if (f[30:23] == 8'd0 || sh > 8'd23) return 24'd0;
        return {1'b1, f[22:0]} >> sh;
    endfunction

    function automatic logic [24:0] isqrt(input logic [49:0] v);
        logic [24:0] root;
        logic [24:0] cand;
        root = '0;
        for (int b = 24; b >= 0; b--) begin
            cand = root | (25'd1 << b);
            if (50'(cand) * 50'(cand) <= v) root = cand;
        end
        return root;
    endfunction

    // num/den is in [0,1]; the quotient carries 24 fraction bits before repacking.
    function automatic logic [31:0] ratio_fp(input logic sign, input logic [23:0] num,
                                             input logic [24:0] den);
        logic [24:0] q;
        int          p;
        if (num == 24'd0 || den == 25'd0) return 32'd0;
        q = 25'((50'(num) << 24) / 50'(den));
        p = 0;
        for (int b = 0; b < 25; b++) if (q[b]) p = b;
        return {sign, 8'(p + 103), 23'({q, 23'd0} >> p)};
    endfunction

    logic [7:0]  emax;
    logic [23:0] ax, ay, az;
    logic [24:0] norm;
    logic [95:0] res;

    always_comb begin
        emax = in_x[30:23];
        if (in_y[30:23] > emax) emax = in_y[30:23];
        if (in_z[30:23] > emax) emax = in_z[30:23];
        ax   = aligned(in_x[30:0], emax);
        ay   = aligned(in_y[30:0], emax);
        az   = aligned(in_z[30:0], emax);
        norm = isqrt(50'(ax) * 50'(ax) + 50'(ay) * 50'(ay) + 50'(az) * 50'(az));
        res  = {ratio_fp(in_x[31], ax, norm), ratio_fp(in_y[31], ay, norm),
                ratio_fp(in_z[31], az, norm)};
    end

    logic [LAT-1:0] vld_pipe;
    logic [95:0]    dat_pipe [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < LAT; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            dat_pipe[0] <= res;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_valid               = vld_pipe[LAT-1];
    assign {out_x, out_y, out_z}   = dat_pipe[LAT-1];

endmodule

// File: rtl/fp32_norm3_sched.sv
// Round-robin scheduler sharing one fp32_normalize3 core across NREQ requesters.
// Optional FP32_NORM3_SCHED_STATS_EN adds issue and stall counters.
module fp32_norm3_sched
    import fp32_norm3_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LAT   = LAT_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*32-1:0]       req_vx,
    input  logic [NREQ*32-1:0]       req_vy,
    input  logic [NREQ*32-1:0]       req_vz,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [31:0]              resp_x,
    output logic [31:0]              resp_y,
    output logic [31:0]              resp_z,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic                     seq_err
`ifdef FP32_NORM3_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH + 1);

    // Handshake: a requester transfers when req_valid[i] && req_ready[i] at posedge;
    // the result side transfers when resp_valid && resp_ready at posedge.
    state_t          state;
    logic [IDW-1:0]  rr_ptr, gid;
    logic [NREQ-1:0] grant;
    logic [CW-1:0]   inflight, inflight_nxt, fifo_count, fifo_nxt;
    logic            credit_ok, accept, rd_fire;

    logic            iss_valid;
    logic [IDW-1:0]  iss_id;
    logic [31:0]     iss_x, iss_y, iss_z;
    logic            core_ov;
    logic [31:0]     core_x, core_y, core_z;
    tag_t            tag_pipe [LAT];
    tag_t            tail;

    // Scan from the far end so the candidate closest to the pointer wins.
    always_comb begin
        grant = '0;
        gid   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                grant = '0;
                grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
                gid   = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
    assign req_ready = (!rst && state == RUN && credit_ok) ? grant : '0;
    assign accept    = |req_ready;
    assign tail      = tag_pipe[LAT-1];
    assign rd_fire   = resp_valid && resp_ready;

    assign inflight_nxt = inflight + CW'(accept) - CW'(core_ov && inflight != '0);
    assign fifo_nxt     = fifo_count + CW'(core_ov) - CW'(rd_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            inflight  <= '0;
            iss_valid <= 1'b0;
            iss_id    <= '0;
            iss_x     <= '0;
            iss_y     <= '0;
            iss_z     <= '0;
            seq_err   <= 1'b0;
            for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
        end else begin
            inflight  <= inflight_nxt;
            iss_valid <= accept;
            if (accept) begin
                rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
                iss_id <= gid;
                iss_x  <= req_vx[int'(gid)*32 +: 32];
                iss_y  <= req_vy[int'(gid)*32 +: 32];
                iss_z  <= req_vz[int'(gid)*32 +: 32];
            end
            tag_pipe[0].valid <= iss_valid;
            tag_pipe[0].id    <= ID_MAX_W'(iss_id);
            for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (core_ov != tail.valid) seq_err <= 1'b1;
        end
    end

    // DONE is entered as soon as the block will be empty after this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            drain_done <= 1'b0;
        end else begin
            case (state)
                RUN:   if (drain_req) state <= DRAIN;
                DRAIN: if (inflight_nxt == '0 && fifo_nxt == '0) begin
                    state      <= DONE;
                    drain_done <= 1'b1;
                end
                DONE:  if (!drain_req) begin
                    state      <= RUN;
                    drain_done <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

    fp32_normalize3 #(.LAT(LAT)) u_core (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iss_valid),
        .in_x      (iss_x),
        .in_y      (iss_y),
        .in_z      (iss_z),
        .out_valid (core_ov),
        .out_x     (core_x),
        .out_y     (core_y),
        .out_z     (core_z)
    );

    fp32_norm3_fifo #(.DEPTH(DEPTH), .W(IDW + 96), .CW(CW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (core_ov),
        .wr_data  ({IDW'(tail.id), core_x, core_y, core_z}),
        .rd_en    (resp_ready),
        .rd_valid (resp_valid),
        .rd_data  ({resp_id, resp_x, resp_y, resp_z}),
        .count    (fifo_count)
    );

`ifdef FP32_NORM3_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept) stat_issued <= stat_issued + 32'd1;
            if (|req_valid && !accept) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp32_norm3_sched.sv
// Self-checking bench for fp32_norm3_sched: vector table, round-robin model and result scoreboard.
module tb_fp32_norm3_sched;

    localparam int NREQ  = 4;
    localparam int LAT   = 7;
    localparam int DEPTH = 8;
    localparam int IDW   = 2;
    localparam int W     = IDW + 96;
    localparam int NV    = 7;

    typedef struct {
        logic [31:0] vx, vy, vz;
        logic [31:0] ex, ey, ez;
    } vec_t;

    vec_t tbl [NV];

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [NREQ*32-1:0]  req_vx, req_vy, req_vz;
    logic                resp_valid, resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_x, resp_y, resp_z;
    logic                drain_req, drain_done, seq_err;
`ifdef FP32_NORM3_SCHED_STATS_EN
    logic [31:0]         stat_issued, stat_stall;
`endif

    fp32_norm3_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vx     (req_vx),
        .req_vy     (req_vy),
        .req_vz     (req_vz),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_x     (resp_x),
        .resp_y     (resp_y),
        .resp_z     (resp_z),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .seq_err    (seq_err)
`ifdef FP32_NORM3_SCHED_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stall (stat_stall)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, acc_total = 0, acc_cyc = -1, resp_cyc = -1;
    int exp_ptr = 0;
    int cur [NREQ];
    int g_cnt [NREQ];
    bit resp_now;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic bit near(input logic [31:0] a, input logic [31:0] e);
        int da, de;
        if (e[30:0] == 31'd0) return a[30:0] == 31'd0;
        if (a[31] !== e[31]) return 1'b0;
        da = int'(a[30:0]);
        de = int'(e[30:0]);
        return (da - de <= 4) && (de - da <= 4);
    endfunction

    task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!near(act, exp)) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h (+/-4 ulp)", name, act, exp);
        end
    endtask

    // driver
    task automatic drive_vecs();
        for (int i = 0; i < NREQ; i++) begin
            req_vx[i*32 +: 32] = tbl[cur[i]].vx;
            req_vy[i*32 +: 32] = tbl[cur[i]].vy;
            req_vz[i*32 +: 32] = tbl[cur[i]].vz;
        end
    endtask

    // One clock: sample both handshakes mid-cycle, then update inputs after the edge.
    task automatic tick();
        logic [W-1:0] e;
        int exp_idx;
        @(negedge clk);
        cyc++;
        resp_now = 1'b0;
        if (req_ready != '0) begin
            exp_idx = -1;
            for (int k = NREQ - 1; k >= 0; k--)
                if (req_valid[(exp_ptr + k) % NREQ]) exp_idx = (exp_ptr + k) % NREQ;
            check("rr_grant", 64'(req_ready), (exp_idx < 0) ? 64'd0 : (64'd1 << exp_idx));
            if (exp_idx >= 0) exp_ptr = (exp_idx + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_q.push_back({IDW'(i), tbl[cur[i]].ex, tbl[cur[i]].ey, tbl[cur[i]].ez});
                cur[i] = (cur[i] + 1) % NV;
                acc_total++;
                g_cnt[i]++;
                acc_cyc = cyc;
            end
        end
        if (resp_valid && resp_ready) begin
            resp_now = 1'b1;
            resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_id", 64'(resp_id), 64'(e[W-1:96]));
                check_near("resp_x", resp_x, e[95:64]);
                check_near("resp_y", resp_y, e[63:32]);
                check_near("resp_z", resp_z, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
        drive_vecs();
    endtask

    task automatic wait_acc(input int target, input int bound, input string name);
        int k;
        k = 0;
        while (acc_total < target && k < bound) begin
            tick();
            k++;
        end
        n_cmp++;
        if (acc_total < target) begin
            n_fail++;
            $display("FAIL %s: timeout with %0d accepts, required %0d", name, acc_total, target);
        end
    endtask

    task automatic wait_empty(input int bound, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: timeout with %0d results outstanding, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        int base, p0, total, expc, k, dd_early, nresp;
        int snap [NREQ];

        tbl[0] = '{32'h40400000, 32'h00000000, 32'h40800000, 32'h3F19999A, 32'h00000000, 32'h3F4CCCCD};
        tbl[1] = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000};
        tbl[2] = '{32'h00000000, 32'hC0000000, 32'h00000000, 32'h00000000, 32'hBF800000, 32'h00000000};
        tbl[3] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F2AAAAB, 32'h3F2AAAAB, 32'h3EAAAAAB};
        tbl[4] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3EAAAAAB, 32'h3F2AAAAB, 32'h3F2AAAAB};
        tbl[5] = '{32'hC0C00000, 32'h00000000, 32'h41000000, 32'hBF19999A, 32'h00000000, 32'h3F4CCCCD};
        tbl[6] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        for (int i = 0; i < NREQ; i++) begin
            cur[i]   = 0;
            g_cnt[i] = 0;
        end

        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        drain_req  = 1'b0;
        drive_vecs();

        // reset state
        repeat (3) tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_x", 64'(resp_x), 64'd0);
        check("rst_resp_y", 64'(resp_y), 64'd0);
        check("rst_resp_z", 64'(resp_z), 64'd0);
        check("rst_drain_done", 64'(drain_done), 64'd0);
        check("rst_seq_err", 64'(seq_err), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // single request from requester 2, latency LAT+2
        resp_ready = 1'b1;
        cur[2] = 0;
        drive_vecs();
        req_valid = 4'b0100;
        wait_acc(acc_total + 1, 10, "single_accept");
        req_valid = '0;
        resp_cyc = -1;
        k = 0;
        while (!resp_now && k < 20) begin
            tick();
            k++;
        end
        check("single_latency", 64'(resp_cyc - acc_cyc), 64'(LAT + 2));

        // table-driven vectors, one per requester in turn
        for (int v = 0; v < NV; v++) begin
            cur[v % NREQ] = v;
            drive_vecs();
            req_valid = NREQ'(1) << (v % NREQ);
            wait_acc(acc_total + 1, 20, "table_accept");
            req_valid = '0;
        end
        wait_empty(60, "table_drain");

        // fairness with all requesters valid
        p0 = exp_ptr;
        base = acc_total;
        for (int i = 0; i < NREQ; i++) snap[i] = g_cnt[i];
        req_valid = '1;
        repeat (40) tick();
        req_valid = '0;
        total = acc_total - base;
        for (int i = 0; i < NREQ; i++) begin
            expc = total / NREQ + ((((i - p0 + NREQ) % NREQ) < (total % NREQ)) ? 1 : 0);
            check("fair_grants", 64'(g_cnt[i] - snap[i]), 64'(expc));
        end
        wait_empty(60, "fair_drain");

        // backpressure: exactly DEPTH accepts, then release
        resp_ready = 1'b0;
        base = acc_total;
        req_valid = '1;
        repeat (30) tick();
        check("bp_accepts", 64'(acc_total - base), 64'(DEPTH));
        check("bp_ready_low", 64'(req_ready), 64'd0);
        req_valid = '0;
        resp_ready = 1'b1;
        wait_empty(40, "bp_drain");
        base = acc_total;
        req_valid = '1;
        repeat (3) tick();
        req_valid = '0;
        check("bp_resume", 64'(acc_total - base), 64'd3);
        wait_empty(40, "bp_resume_drain");

        // drain with 3 ops in flight
        base = acc_total;
        req_valid = '1;
        wait_acc(base + 2, 10, "drain_accept");
        drain_req = 1'b1;
        repeat (3) tick();
        check("drain_accepts", 64'(acc_total - base), 64'd3);
        dd_early = 0;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            tick();
            k++;
            if (drain_done && exp_q.size() != 0) dd_early++;
        end
        check("drain_done_early", 64'(dd_early), 64'd0);
        check("drain_done_rise", 64'(drain_done), 64'd1);
        base = acc_total;
        repeat (2) tick();
        check("done_ready_low", 64'(req_ready), 64'd0);
        check("done_hold", 64'(drain_done), 64'd1);
        check("done_no_accept", 64'(acc_total - base), 64'd0);
        drain_req = 1'b0;
        tick();
        wait_acc(acc_total + 1, 4, "run_resume");
        req_valid = '0;
        check("run_drain_done", 64'(drain_done), 64'd0);
        wait_empty(40, "run_drain");

        // reset mid-flight after 2 accepts
        base = acc_total;
        req_valid = 4'b0011;
        wait_acc(base + 2, 10, "rst_accept");
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_ptr = 0;
        nresp = 0;
        repeat (20) begin
            tick();
            if (resp_valid) nresp++;
        end
        check("rst_no_resp", 64'(nresp), 64'd0);
        check("rst_seq_err_mid", 64'(seq_err), 64'd0);

`ifdef FP32_NORM3_SCHED_STATS_EN
        // statistics: 10 accepts and 6 stalled cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_ptr = 0;
        resp_ready = 1'b0;
        base = acc_total;
        req_valid = '1;
        wait_acc(base + DEPTH, 20, "stat_fill");
        repeat (6) tick();
        req_valid = '0;
        resp_ready = 1'b1;
        wait_empty(40, "stat_drain");
        req_valid = 4'b0001;
        wait_acc(base + 10, 10, "stat_tail");
        req_valid = '0;
        check("stat_issued", 64'(stat_issued), 64'd10);
        check("stat_stall", 64'(stat_stall), 64'd6);
        wait_empty(40, "stat_final_drain");
`endif

        check("final_seq_err", 64'(seq_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_norm3_sched.md
FP32_NORM3_SCHED -- requirements
Module: fp32_norm3_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one normalize core; legal range 2..8.
REQ-002 Parameter LAT, default 7, core in_valid-to-out_valid latency in cycles.
REQ-003 Parameter DEPTH, default 8, result FIFO entries; DEPTH SHALL be at least LAT+1.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-008 req_vx, req_vy, req_vz  input  NREQ*32 each  packed FP32 vector components; slice i belongs to requester i.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_id  output  clog2(NREQ)  requester index of the presented result.
REQ-012 resp_x, resp_y, resp_z  output  32 each  normalized FP32 components.
REQ-013 drain_req  input  1  level request to stop accepting and empty the block.
REQ-014 drain_done  output  1  asserted while drained and idle.
REQ-015 seq_err  output  1  sticky flag for tag/core valid mismatch.

Function
REQ-016 Arbitration: round-robin across asserted req_valid; the pointer advances to one past the granted index after each grant; at most one grant per cycle.
REQ-017 Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high; req_ready SHALL NOT depend combinationally on req_valid of the same requester beyond arbitration.
REQ-018 Credit: grant only when inflight + fifo_count < DEPTH; inflight counts issued ops not yet returned by the core.
REQ-019 Issue: the granted vector and its id are registered; core in_valid is asserted in the cycle after acceptance.
REQ-020 Tag pipeline: a LAT-deep shift register carries {valid, id} alongside the core; when the core asserts out_valid, its result and the tag-pipe id are written to the FIFO.
REQ-021 If core out_valid differs from the tag-pipe tail valid in any cycle, seq_err SHALL set and hold until rst; a result is still written when core out_valid is high.
REQ-022 Latency: with an empty FIFO, accept at cycle t gives resp_valid at t+LAT+2.
REQ-023 Ordering: results leave in issue order; the FIFO is a first-word-fall-through buffer.
REQ-024 FIFO full with a core result arriving is unreachable by REQ-018; simultaneous write and read at full or empty SHALL be legal with correct count.
REQ-025 FSM states: RUN, DRAIN, DONE. RUN->DRAIN on drain_req; DRAIN->DONE when inflight==0 and FIFO empty; DONE->RUN when drain_req drops; req_ready=0 in DRAIN and DONE.
REQ-026 drain_done is high only in DONE.

Reset
REQ-027 On rst: req_ready=0, resp_valid=0, resp_id=0, resp_x/y/z=0, drain_done=0, seq_err=0, FSM=RUN, RR pointer=0, counts=0, tag pipe cleared, core reset.
REQ-028 rst asserted mid-operation discards all in-flight and buffered results; no result is emitted for pre-reset requests.

Configuration
REQ-029 Macro FP32_NORM3_SCHED_STATS_EN: when defined, adds outputs stat_issued (32-bit, accepted-request count) and stat_stall (32-bit, cycles with any req_valid high and no grant), both wrapping and cleared by rst; when undefined, these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-030 A shared package fp32_norm3_pkg holds the FSM state enum, the tag struct {valid, id}, and the default LAT constant 7.
REQ-031 The block instantiates fp32_normalize3 internally, and one sub-module fp32_norm3_fifo (parameterized FWFT FIFO, payload = id plus 96 data bits).

Verification
REQ-032 Single request: requester 2 sends (3.0, 0.0, 4.0) at cycle 0 -> resp at cycle 9, resp_id=2, result approx (0.6, 0.0, 0.8) within inv-sqrt tolerance.
REQ-033 Fairness: all 4 requesters hold valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0...; every requester gets one grant per 4 cycles.
REQ-034 Backpressure: resp_ready=0 with continuous requests -> exactly DEPTH accepts, then req_ready=0; release resp_ready -> the DEPTH results drain in order, then accepts resume.
REQ-035 Drain: drain_req raised with 3 ops in flight -> no new grants; drain_done rises in the cycle after the 3rd result is consumed; lowering drain_req returns to RUN.
REQ-036 Reset mid-flight: rst for 1 cycle at cycle 4 after 2 accepts -> no resp_valid in the following 20 cycles; seq_err stays 0.
REQ-037 With FP32_NORM3_SCHED_STATS_EN: 10 accepts and 6 stalled cycles -> stat_issued=10, stat_stall=6.
